// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: read-mode enum,
// width helpers and the parameter-legality predicate used at elaboration.
package fifo_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  // Pointer width: one bit per address line, natural wrap at FIFO_DEPTH.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: one extra bit so FIFO_DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int width, input int depth,
                                      input int afull_th, input int aempty_th,
                                      input int fwft);
    return (width >= 1) && (depth >= 4) && is_pow2(depth) &&
           (afull_th >= 1) && (afull_th <= depth - 1) &&
           (aempty_th >= 1) && (aempty_th <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_flags.sv
// Occupancy flag decode: full/empty/almostfull/almostempty from the count.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_TH   = 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        almostfull,
  output logic                        almostempty
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LVL_C = CW'(FIFO_DEPTH - AFULL_TH);
  localparam logic [CW-1:0] AE_LVL_C = CW'(AEMPTY_TH);

  // Almost-flags exclude the hard full/empty states so each is a band.
  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almostfull  = (count != DEPTH_C) && (count >= AF_LVL_C);
    almostempty = (count != '0) && (count <= AE_LVL_C);
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// Parametrised single-clock FIFO with programmable almost-thresholds,
// standard or first-word-fall-through read port, and synchronous flush.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_TH   = 1,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        rd_en,
  output logic [FIFO_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        full,
  output logic                        empty,
  output logic                        almostfull,
  output logic                        almostempty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int       PW   = ptr_width(FIFO_DEPTH);
  localparam int       CW   = cnt_width(FIFO_DEPTH);
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

  if (!params_legal(FIFO_WIDTH, FIFO_DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
    $error("fifo_sync_prog: illegal parameter combination");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;

  logic rd_acc;
  logic wr_acc;
  logic rd_do;
  logic wr_do;

  // A write at full is allowed only when a read frees the head this cycle;
  // flush overrides both requests.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign rd_do  = rd_acc && !flush;
  assign wr_do  = wr_acc && !flush;

  assign count = count_q;

  fifo_flags #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .AFULL_TH   (AFULL_TH),
    .AEMPTY_TH  (AEMPTY_TH)
  ) u_flags (
    .count       (count_q),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty)
  );

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_do, rd_do})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointers and count; flush returns them to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + PW'(1);
      if (rd_do) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_nxt;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= data_in;
  end

  // Per-request status pulses, reported the cycle after the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc && !flush;
      overflow  <= wr_en && !wr_acc && !flush;
      underflow <= rd_en && empty && !flush;
    end
  end

  if (MODE == RD_FWFT) begin : g_fwft
    // Head entry is presented directly; zero while nothing is stored.
    assign data_out   = empty ? '0 : mem[rd_ptr];
    assign data_valid = !empty;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  dv_q;

    // Registered read port: load on accepted read, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_do;
        if (rd_do) dout_q <= mem[rd_ptr];
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: a standard-mode and an FWFT-mode instance share
// one stimulus stream and are compared against a queue-based reference.
module tb_fifo_sync_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;

  logic [15:0] s_dout, f_dout;
  logic        s_dv, s_ack, s_ovf, s_udf, s_full, s_empty, s_af, s_ae;
  logic        f_dv, f_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae;
  logic [3:0]  s_count, f_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AFULL_TH(1), .AEMPTY_TH(1), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(s_dout), .data_valid(s_dv), .wr_ack(s_ack),
    .overflow(s_ovf), .underflow(s_udf), .full(s_full), .empty(s_empty),
    .almostfull(s_af), .almostempty(s_ae), .count(s_count)
  );

  fifo_sync_prog #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AFULL_TH(2), .AEMPTY_TH(3), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(f_dout), .data_valid(f_dv), .wr_ack(f_ack),
    .overflow(f_ovf), .underflow(f_udf), .full(f_full), .empty(f_empty),
    .almostfull(f_af), .almostempty(f_ae), .count(f_count)
  );

  logic [27:0] obs_std;
  logic [11:0] obs_fwft;
  assign obs_std  = {s_count, s_full, s_empty, s_af, s_ae, s_ack, s_ovf, s_udf, s_dv, s_dout};
  assign obs_fwft = {f_count, f_full, f_empty, f_af, f_ae, f_ack, f_ovf, f_udf, f_dv};

  // Reference model state: stored words in order plus last-cycle status.
  logic [15:0] m_q[$];
  logic        m_ack, m_ovf, m_udf, m_dv;
  logic [15:0] m_dout;

  function automatic logic [27:0] exp_std();
    int n;
    n = m_q.size();
    return {4'(n), 1'(n == 8), 1'(n == 0), 1'(n != 8 && n >= 7), 1'(n != 0 && n <= 1),
            m_ack, m_ovf, m_udf, m_dv, m_dout};
  endfunction

  function automatic logic [11:0] exp_fwft();
    int n;
    n = m_q.size();
    return {4'(n), 1'(n == 8), 1'(n == 0), 1'(n != 8 && n >= 6), 1'(n != 0 && n <= 3),
            m_ack, m_ovf, m_udf, 1'(n != 0)};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = '0;
  endtask

  // One clock of stimulus; the model applies the FIFO rules at the edge.
  task automatic cyc(input logic f, input logic w, input logic r, input logic [15:0] d);
    int   n;
    logic rok, wok;
    flush = f; wr_en = w; rd_en = r; data_in = d;
    @(posedge clk);
    n = m_q.size();
    if (f) begin
      m_q.delete();
      m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0;
    end else begin
      rok   = r && (n > 0);
      wok   = w && ((n < 8) || rok);
      m_udf = r && (n == 0);
      m_ovf = w && !wok;
      m_ack = wok;
      m_dv  = rok;
      if (rok) m_dout = m_q.pop_front();
      if (wok) m_q.push_back(d);
    end
    #1;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs_std !== {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 16'h0000}) begin
      bad++; $display("FAIL reset_std got=%h want=%h", obs_std, {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 16'h0000});
    end
    total++;
    if (obs_fwft !== {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000}) begin
      bad++; $display("FAIL reset_fwft got=%h want=%h", obs_fwft, {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000});
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'(i));
      total++;
      if (obs_std !== exp_std()) begin
        bad++; $display("FAIL fill_std[%0d] got=%h want=%h", i, obs_std, exp_std());
      end
      total++;
      if (obs_fwft !== exp_fwft()) begin
        bad++; $display("FAIL fill_fwft[%0d] got=%h want=%h", i, obs_fwft, exp_fwft());
      end
      if (i == 7) begin
        total++;
        if ({s_af, s_full} !== 2'b10) begin
          bad++; $display("FAIL fill_af7 got=%b want=10", {s_af, s_full});
        end
      end
      if (i == 8) begin
        total++;
        if ({s_af, s_full, s_ack} !== 3'b011) begin
          bad++; $display("FAIL fill_full8 got=%b want=011", {s_af, s_full, s_ack});
        end
      end
    end
    total++;
    if ({s_ovf, s_ack, s_count} !== {1'b1, 1'b0, 4'd8}) begin
      bad++; $display("FAIL fill_overflow got=%h want=%h", {s_ovf, s_ack, s_count}, {1'b1, 1'b0, 4'd8});
    end
  endtask

  task automatic test_drain_std();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0);
      total++;
      if (obs_std !== exp_std()) begin
        bad++; $display("FAIL drain_std[%0d] got=%h want=%h", i, obs_std, exp_std());
      end
      total++;
      if ({s_dv, s_dout} !== {1'b1, 16'(i)}) begin
        bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, {s_dv, s_dout}, {1'b1, 16'(i)});
      end
      if (i == 7) begin
        total++;
        if ({s_ae, s_empty} !== 2'b10) begin
          bad++; $display("FAIL drain_ae1 got=%b want=10", {s_ae, s_empty});
        end
      end
    end
    total++;
    if ({s_ae, s_empty} !== 2'b01) begin
      bad++; $display("FAIL drain_empty got=%b want=01", {s_ae, s_empty});
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    total++;
    if ({s_udf, s_dv, s_dout} !== {1'b1, 1'b0, 16'h0008}) begin
      bad++; $display("FAIL drain_underflow got=%h want=%h", {s_udf, s_dv, s_dout}, {1'b1, 1'b0, 16'h0008});
    end
  endtask

  task automatic test_wrap();
    int plan[4] = '{6, 6, 8, 8};
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < plan[p]; k++) begin
        cyc(1'b0, (p % 2) == 0, (p % 2) == 1, 16'($urandom));
        total++;
        if (obs_std !== exp_std()) begin
          bad++; $display("FAIL wrap_std[%0d.%0d] got=%h want=%h", p, k, obs_std, exp_std());
        end
        total++;
        if (obs_fwft !== exp_fwft()) begin
          bad++; $display("FAIL wrap_fwft[%0d.%0d] got=%h want=%h", p, k, obs_fwft, exp_fwft());
        end
        if (m_q.size() > 0) begin
          total++;
          if (f_dout !== m_q[0]) begin
            bad++; $display("FAIL wrap_fwft_head got=%h want=%h", f_dout, m_q[0]);
          end
        end
      end
    end
    total++;
    if ({s_count, s_empty} !== {4'd0, 1'b1}) begin
      bad++; $display("FAIL wrap_end got=%h want=%h", {s_count, s_empty}, {4'd0, 1'b1});
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] first;
    first = 16'h0100;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, first + 16'(i));
    cyc(1'b0, 1'b1, 1'b1, 16'hAAAA);
    total++;
    if ({s_dout, s_dv, s_count, s_full, s_ovf, s_ack} !== {first, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL both_at_full got=%h want=%h", {s_dout, s_dv, s_count, s_full, s_ovf, s_ack},
                      {first, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1});
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0);
      total++;
      if (obs_std !== exp_std()) begin
        bad++; $display("FAIL both_drain[%0d] got=%h want=%h", i, obs_std, exp_std());
      end
    end
    total++;
    if (s_dout !== 16'hAAAA) begin
      bad++; $display("FAIL both_last got=%h want=aaaa", s_dout);
    end
    cyc(1'b0, 1'b1, 1'b1, 16'h5555);
    total++;
    if ({s_count, s_udf, s_ack, f_dout, f_dv} !== {4'd1, 1'b1, 1'b1, 16'h5555, 1'b1}) begin
      bad++; $display("FAIL both_at_empty got=%h want=%h", {s_count, s_udf, s_ack, f_dout, f_dv},
                      {4'd1, 1'b1, 1'b1, 16'h5555, 1'b1});
    end
  endtask

  task automatic test_fwft();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 16'h1234);
    total++;
    if ({f_dv, f_dout, f_ae, f_count} !== {1'b1, 16'h1234, 1'b1, 4'd1}) begin
      bad++; $display("FAIL fwft_first got=%h want=%h", {f_dv, f_dout, f_ae, f_count}, {1'b1, 16'h1234, 1'b1, 4'd1});
    end
    for (int n = 2; n <= 8; n++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
      total++;
      if ({f_ae, f_af} !== {1'(n <= 3), 1'(n >= 6 && n <= 7)}) begin
        bad++; $display("FAIL fwft_thresh[%0d] got=%b want=%b", n, {f_ae, f_af}, {1'(n <= 3), 1'(n >= 6 && n <= 7)});
      end
      total++;
      if (f_dout !== 16'h1234) begin
        bad++; $display("FAIL fwft_head_hold[%0d] got=%h want=1234", n, f_dout);
      end
    end
    for (int n = 7; n >= 0; n--) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0);
      total++;
      if (obs_fwft !== exp_fwft()) begin
        bad++; $display("FAIL fwft_pop[%0d] got=%h want=%h", n, obs_fwft, exp_fwft());
      end
      if (m_q.size() > 0) begin
        total++;
        if (f_dout !== m_q[0]) begin
          bad++; $display("FAIL fwft_pop_head[%0d] got=%h want=%h", n, f_dout, m_q[0]);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0A00 + 16'(i));
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0A05);
    cyc(1'b1, 1'b1, 1'b1, 16'hDEAD);
    total++;
    if ({s_count, s_empty, s_ack, s_ovf, s_udf, s_dv, s_dout} !== {4'd0, 1'b1, 4'b0000, 16'h0A00}) begin
      bad++; $display("FAIL flush_state got=%h want=%h", {s_count, s_empty, s_ack, s_ovf, s_udf, s_dv, s_dout},
                      {4'd0, 1'b1, 4'b0000, 16'h0A00});
    end
    cyc(1'b0, 1'b1, 1'b0, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    total++;
    if ({s_dout, s_dv, s_empty} !== {16'hBEEF, 1'b1, 1'b1}) begin
      bad++; $display("FAIL flush_after got=%h want=%h", {s_dout, s_dv, s_empty}, {16'hBEEF, 1'b1, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    wr_en = 1'b1; rd_en = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs_std !== {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 16'h0000}) begin
      bad++; $display("FAIL reset_mid_std got=%h want=%h", obs_std, {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 16'h0000});
    end
    total++;
    if (obs_fwft !== {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000}) begin
      bad++; $display("FAIL reset_mid_fwft got=%h want=%h", obs_fwft, {4'd0, 1'b0, 1'b1, 2'b00, 4'b0000});
    end
    wr_en = 1'b0; rd_en = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    int wbias;
    for (int i = 0; i < 400; i++) begin
      wbias = (i < 200) ? 3 : 1;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) < wbias, $urandom_range(0, 3) >= wbias,
          16'($urandom));
      total++;
      if (obs_std !== exp_std()) begin
        bad++; $display("FAIL rand_std[%0d] got=%h want=%h", i, obs_std, exp_std());
      end
      total++;
      if (obs_fwft !== exp_fwft()) begin
        bad++; $display("FAIL rand_fwft[%0d] got=%h want=%h", i, obs_fwft, exp_fwft());
      end
      if (m_q.size() > 0) begin
        total++;
        if (f_dout !== m_q[0]) begin
          bad++; $display("FAIL rand_fwft_head[%0d] got=%h want=%h", i, f_dout, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_drain_std();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
